// File: rtl/tcam_mode_sched.sv
// -----------------------------------------------------------------------------
// tcam_mode_sched
// Shares one TCAM Mem block between a host configuration port (write, read,
// re-init) and a spike-packet stream (fire). After reset, and on a host re-init,
// it replays the Mem power-up sequence: MODE_RST is held for RST_CYCLES clock edges.
// It arbitrates the two requesters. It drives Mem's MODE/Data_In/Mskb_In/
// A_In/PacketID_In from registers, and returns read data on a one-cycle strobe.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   host_valid/host_ready           host request handshake
//   host_op                         00 write, 01 read, 10 reserved, 11 re-init
//   host_addr/data/mskb/dcs/vbe/vbi host request payload
//   pkt_valid/pkt_ready/pkt_id      spike packet handshake and ID
//   rd_valid, rd_data               read response strobe and held data
//   err                             one-cycle pulse on an accepted reserved op
//   busy                            scheduler not idle
//   mem_mode .. mem_vbi             registered Mem controls
//   mem_do                          Mem read data (valid the cycle after MODE_R)
//   fire_cnt                        FIRE cycle counter (optional, see below)
//
// Optional feature: define TCAM_SCHED_FIRE_CNT_EN to add the 16-bit fire_cnt
// output. It counts FIRE cycles, wraps, and clears on reset and on re-init.
// -----------------------------------------------------------------------------
module tcam_mode_sched #(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int RST_CYCLES  = 2,
  parameter int HOST_BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [1:0]             host_op,
  input  logic [AddressSize-1:0] host_addr,
  input  logic [Bits-1:0]        host_data,
  input  logic [Bits-1:0]        host_mskb,
  input  logic                   host_dcs,
  input  logic                   host_vbe,
  input  logic                   host_vbi,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [ID_Width-1:0]    pkt_id,
  output logic                   rd_valid,
  output logic [Bits-1:0]        rd_data,
  output logic                   err,
  output logic                   busy,
  output logic [2:0]             mem_mode,
  output logic [ID_Width-1:0]    mem_packet_id,
  output logic [Bits-1:0]        mem_data,
  output logic [Bits-1:0]        mem_mskb,
  output logic [AddressSize-1:0] mem_a,
  output logic                   mem_dcs,
  output logic                   mem_vbe,
  output logic                   mem_vbi,
  input  logic [Bits-1:0]        mem_do
`ifdef TCAM_SCHED_FIRE_CNT_EN
  ,
  output logic [15:0]            fire_cnt
`endif
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int BCW = $clog2(HOST_BURST + 1);

  localparam logic [2:0] MODE_I   = 3'b000;
  localparam logic [2:0] MODE_W   = 3'b001;
  localparam logic [2:0] MODE_R   = 3'b010;
  localparam logic [2:0] MODE_F   = 3'b011;
  localparam logic [2:0] MODE_RST = 3'b101;

  typedef enum logic [2:0] {
    S_RSTSEQ, S_IDLE, S_WR, S_RD, S_RDCAP, S_FIRE
  } state_t;

  state_t                 state_q, state_d;
  logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [BCW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [2:0]             mem_mode_q, mem_mode_d;
  logic [ID_Width-1:0]    mem_packet_id_q, mem_packet_id_d;
  logic [Bits-1:0]        mem_data_q, mem_data_d;
  logic [Bits-1:0]        mem_mskb_q, mem_mskb_d;
  logic [AddressSize-1:0] mem_a_q, mem_a_d;
  logic                   mem_dcs_q, mem_dcs_d;
  logic                   mem_vbe_q, mem_vbe_d;
  logic                   mem_vbi_q, mem_vbi_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [Bits-1:0]        rd_data_q, rd_data_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   grant_host;

  // Host wins a tie unless it has already taken HOST_BURST grants in a row
  // while a packet was waiting.
  always_comb begin
    grant_host = host_valid & ~(pkt_valid & (burst_cnt_q == BCW'(HOST_BURST)));
    host_ready = (state_q == S_IDLE) & grant_host;
    pkt_ready  = (state_q == S_IDLE) & pkt_valid & ~grant_host;
  end

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    mem_mode_d      = MODE_I;
    mem_packet_id_d = '0;
    mem_data_d      = '0;
    mem_mskb_d      = '0;
    mem_a_d         = '0;
    mem_dcs_d       = 1'b0;
    mem_vbe_d       = 1'b0;
    mem_vbi_d       = 1'b0;
    rd_valid_d      = 1'b0;
    rd_data_d       = rd_data_q;
    err_d           = 1'b0;

    case (state_q)
      S_RSTSEQ: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = S_IDLE;
          rst_cnt_d = '0;
        end else begin
          mem_mode_d = MODE_RST;
          rst_cnt_d  = rst_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (host_ready) begin
          case (host_op)
            2'b00: begin
              state_d    = S_WR;
              mem_mode_d = MODE_W;
              mem_a_d    = host_addr;
              mem_data_d = host_data;
              mem_mskb_d = host_mskb;
              mem_dcs_d  = host_dcs;
              mem_vbe_d  = host_vbe;
              mem_vbi_d  = host_vbi;
            end
            2'b01: begin
              state_d    = S_RD;
              mem_mode_d = MODE_R;
              mem_a_d    = host_addr;
              mem_dcs_d  = host_dcs;
              mem_vbe_d  = host_vbe;
            end
            2'b10: err_d = 1'b1;
            default: begin
              state_d    = S_RSTSEQ;
              rst_cnt_d  = '0;
              mem_mode_d = MODE_RST;
            end
          endcase
        end else if (pkt_ready) begin
          state_d         = S_FIRE;
          mem_mode_d      = MODE_F;
          mem_packet_id_d = pkt_id;
        end
      end
      S_RD:    state_d = S_RDCAP;
      S_RDCAP: begin
        // Mem data is valid in the cycle after MODE_R was presented.
        state_d    = S_IDLE;
        rd_data_d  = mem_do;
        rd_valid_d = 1'b1;
      end
      S_WR, S_FIRE: state_d = S_IDLE;
      default: begin
        state_d    = S_RSTSEQ;
        rst_cnt_d  = '0;
        mem_mode_d = MODE_RST;
      end
    endcase

    if (!pkt_valid || pkt_ready) begin
      burst_cnt_d = '0;
    end else if (host_ready && (burst_cnt_q != BCW'(HOST_BURST))) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end

    // busy is registered from the next state so that it reads 0 while rst_n is
    // held low and otherwise tracks state != IDLE.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_RSTSEQ;
      rst_cnt_q       <= '0;
      burst_cnt_q     <= '0;
      mem_mode_q      <= MODE_RST;
      mem_packet_id_q <= '0;
      mem_data_q      <= '0;
      mem_mskb_q      <= '0;
      mem_a_q         <= '0;
      mem_dcs_q       <= 1'b0;
      mem_vbe_q       <= 1'b0;
      mem_vbi_q       <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      burst_cnt_q     <= burst_cnt_d;
      mem_mode_q      <= mem_mode_d;
      mem_packet_id_q <= mem_packet_id_d;
      mem_data_q      <= mem_data_d;
      mem_mskb_q      <= mem_mskb_d;
      mem_a_q         <= mem_a_d;
      mem_dcs_q       <= mem_dcs_d;
      mem_vbe_q       <= mem_vbe_d;
      mem_vbi_q       <= mem_vbi_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
    end
  end

  assign mem_mode      = mem_mode_q;
  assign mem_packet_id = mem_packet_id_q;
  assign mem_data      = mem_data_q;
  assign mem_mskb      = mem_mskb_q;
  assign mem_a         = mem_a_q;
  assign mem_dcs       = mem_dcs_q;
  assign mem_vbe       = mem_vbe_q;
  assign mem_vbi       = mem_vbi_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign err           = err_q;
  assign busy          = busy_q;

`ifdef TCAM_SCHED_FIRE_CNT_EN
  logic [15:0] fire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt_q <= '0;
    end else if (host_ready && (host_op == 2'b11)) begin
      fire_cnt_q <= '0;
    end else if (state_q == S_FIRE) begin
      fire_cnt_q <= fire_cnt_q + 16'd1;
    end
  end

  assign fire_cnt = fire_cnt_q;
`endif

endmodule

// File: tb/tb_tcam_mode_sched.sv
module tb_tcam_mode_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid;
  logic       host_ready;
  logic [1:0] host_op;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic [7:0] host_mskb;
  logic       host_dcs;
  logic       host_vbe;
  logic       host_vbi;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [3:0] pkt_id;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       err;
  logic       busy;
  logic [2:0] mem_mode;
  logic [3:0] mem_packet_id;
  logic [7:0] mem_data;
  logic [7:0] mem_mskb;
  logic [3:0] mem_a;
  logic       mem_dcs;
  logic       mem_vbe;
  logic       mem_vbi;
  logic [7:0] mem_do;
`ifdef TCAM_SCHED_FIRE_CNT_EN
  logic [15:0] fire_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tcam_mode_sched dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_op(host_op),
    .host_addr(host_addr), .host_data(host_data), .host_mskb(host_mskb),
    .host_dcs(host_dcs), .host_vbe(host_vbe), .host_vbi(host_vbi),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_id(pkt_id),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .busy(busy),
    .mem_mode(mem_mode), .mem_packet_id(mem_packet_id), .mem_data(mem_data),
    .mem_mskb(mem_mskb), .mem_a(mem_a), .mem_dcs(mem_dcs), .mem_vbe(mem_vbe),
    .mem_vbi(mem_vbi), .mem_do(mem_do)
`ifdef TCAM_SCHED_FIRE_CNT_EN
    , .fire_cnt(fire_cnt)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_valid = 1'b0; host_op = 2'b00; host_addr = '0;
    host_data = '0; host_mskb = '0; host_dcs = 1'b0; host_vbe = 1'b0;
    host_vbi = 1'b0; pkt_valid = 1'b0; pkt_id = '0; mem_do = '0;
    step(); step();
    vectors++;
    if (mem_mode !== 3'b101) begin miscompares++; $display("FAIL rst_mode got %b exp 101", mem_mode); end
    vectors++;
    if ({rd_valid, rd_data, err, busy, mem_packet_id, mem_data, mem_mskb, mem_a, mem_dcs, mem_vbe, mem_vbi} !== '0) begin
      miscompares++; $display("FAIL rst_outs got nonzero outputs busy=%b mem_a=%h", busy, mem_a);
    end
    // Release with both requesters pending: nothing may be accepted until IDLE.
    rst_n = 1'b1; host_valid = 1'b1; host_op = 2'b10; pkt_valid = 1'b1; pkt_id = 4'h1;
    #1;
    vectors++;
    if (host_ready !== 1'b0 || pkt_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready0 got %b%b exp 00", host_ready, pkt_ready); end
    step();
    vectors++;
    if (mem_mode !== 3'b101 || busy !== 1'b1) begin miscompares++; $display("FAIL rst_seq1 got mode=%b busy=%b exp 101/1", mem_mode, busy); end
    vectors++;
    if (host_ready !== 1'b0 || pkt_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got %b%b exp 00", host_ready, pkt_ready); end
    step();
    vectors++;
    if (mem_mode !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_done got mode=%b busy=%b exp 000/0", mem_mode, busy); end
    vectors++;
    if (host_ready !== 1'b1 || pkt_ready !== 1'b0) begin miscompares++; $display("FAIL rst_idle_ready got %b%b exp 10", host_ready, pkt_ready); end
    host_valid = 1'b0; pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_write();
    host_valid = 1'b1; host_op = 2'b00; host_addr = 4'd3; host_data = 8'hA5;
    host_mskb = 8'hFF; host_dcs = 1'b1; host_vbe = 1'b1; host_vbi = 1'b1;
    #1;
    vectors++;
    if (host_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready got %b exp 1", host_ready); end
    step();
    host_valid = 1'b0;
    vectors++;
    if (mem_mode !== 3'b001 || mem_a !== 4'd3 || mem_data !== 8'hA5 || mem_mskb !== 8'hFF)
      begin miscompares++; $display("FAIL wr_fields got mode=%b a=%h d=%h m=%h exp 001/3/a5/ff", mem_mode, mem_a, mem_data, mem_mskb); end
    vectors++;
    if ({mem_dcs, mem_vbe, mem_vbi, busy} !== 4'b1111) begin miscompares++; $display("FAIL wr_bits got %b exp 1111", {mem_dcs, mem_vbe, mem_vbi, busy}); end
    step();
    vectors++;
    if (mem_mode !== 3'b000 || mem_a !== 4'd0 || mem_data !== 8'h00 || mem_mskb !== 8'h00 || busy !== 1'b0)
      begin miscompares++; $display("FAIL wr_after got mode=%b a=%h d=%h busy=%b exp 000/0/00/0", mem_mode, mem_a, mem_data, busy); end
  endtask

  task automatic test_read();
    host_valid = 1'b1; host_op = 2'b01; host_addr = 4'd3; host_data = 8'h77;
    host_dcs = 1'b1; host_vbe = 1'b0; mem_do = 8'h11;
    step();  // accept edge
    host_valid = 1'b0;
    vectors++;
    if (mem_mode !== 3'b010 || mem_a !== 4'd3 || mem_dcs !== 1'b1 || mem_data !== 8'h00)
      begin miscompares++; $display("FAIL rd_issue got mode=%b a=%h dcs=%b d=%h exp 010/3/1/00", mem_mode, mem_a, mem_dcs, mem_data); end
    step();
    vectors++;
    if (mem_mode !== 3'b000 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_cap got mode=%b rv=%b exp 000/0", mem_mode, rd_valid); end
    mem_do = 8'h5A;
    step();
    mem_do = 8'h22;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin miscompares++; $display("FAIL rd_resp got rv=%b data=%h exp 1/5a", rd_valid, rd_data); end
    step();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h5A) begin miscompares++; $display("FAIL rd_hold got rv=%b data=%h exp 0/5a", rd_valid, rd_data); end
  endtask

  task automatic test_reserved();
    host_valid = 1'b1; host_op = 2'b10;
    #1;
    vectors++;
    if (host_ready !== 1'b1) begin miscompares++; $display("FAIL rsv_ready got %b exp 1", host_ready); end
    step();
    host_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || mem_mode !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL rsv_err got err=%b mode=%b busy=%b exp 1/000/0", err, mem_mode, busy); end
    step();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL rsv_pulse got %b exp 0", err); end
  endtask

  task automatic test_arbitration();
    logic exp_h;
    host_valid = 1'b1; host_op = 2'b00; host_addr = 4'd5; host_data = 8'h3C;
    pkt_valid = 1'b1; pkt_id = 4'h9;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_h = ((i % 5) != 4);
      vectors++;
      if (host_ready !== exp_h || pkt_ready !== !exp_h) begin
        miscompares++; $display("FAIL arb_grant[%0d] got h=%b p=%b exp h=%b", i, host_ready, pkt_ready, exp_h);
      end
      step();
      vectors++;
      if (exp_h ? (mem_mode !== 3'b001) : (mem_mode !== 3'b011 || mem_packet_id !== 4'h9)) begin
        miscompares++; $display("FAIL arb_mode[%0d] got mode=%b id=%h exp %s", i, mem_mode, mem_packet_id, exp_h ? "001" : "011/9");
      end
      step();
    end
    host_valid = 1'b0; pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    host_valid = 1'b1; host_op = 2'b01; host_addr = 4'd7; mem_do = 8'h5A;
    step();
    host_valid = 1'b0;
    vectors++;
    if (mem_mode !== 3'b010) begin miscompares++; $display("FAIL mid_rd got mode=%b exp 010", mem_mode); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_mode !== 3'b101 || mem_a !== 4'd0 || busy !== 1'b0 || rd_data !== 8'h00)
      begin miscompares++; $display("FAIL mid_rst got mode=%b a=%h busy=%b rd=%h exp 101/0/0/00", mem_mode, mem_a, busy, rd_data); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rv[%0d] got %b exp 0", i, rd_valid); end
      if (i == 2) begin
        vectors++;
        if (mem_mode !== 3'b101) begin miscompares++; $display("FAIL mid_replay got mode=%b exp 101", mem_mode); end
      end
      if (i == 3) begin
        vectors++;
        if (mem_mode !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_idle got mode=%b busy=%b exp 000/0", mem_mode, busy); end
      end
    end
  endtask

  task automatic test_reinit();
    host_valid = 1'b1; host_op = 2'b11;
    step();
    host_valid = 1'b0;
    vectors++;
    if (mem_mode !== 3'b101 || busy !== 1'b1) begin miscompares++; $display("FAIL reinit1 got mode=%b busy=%b exp 101/1", mem_mode, busy); end
    step();
    vectors++;
    if (mem_mode !== 3'b101 || host_ready !== 1'b0) begin miscompares++; $display("FAIL reinit2 got mode=%b hr=%b exp 101/0", mem_mode, host_ready); end
    step();
    vectors++;
    if (mem_mode !== 3'b000 || busy !== 1'b0) begin miscompares++; $display("FAIL reinit3 got mode=%b busy=%b exp 000/0", mem_mode, busy); end
`ifdef TCAM_SCHED_FIRE_CNT_EN
    vectors++;
    if (fire_cnt !== 16'd0) begin miscompares++; $display("FAIL reinit_fcnt got %0d exp 0", fire_cnt); end
`endif
  endtask

  task automatic test_fire();
    logic [3:0] ids [3];
    ids[0] = 4'hC; ids[1] = 4'h3; ids[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1; pkt_id = ids[i];
      step();
      pkt_valid = 1'b0;
      vectors++;
      if (mem_mode !== 3'b011 || mem_packet_id !== ids[i]) begin
        miscompares++; $display("FAIL fire[%0d] got mode=%b id=%h exp 011/%h", i, mem_mode, mem_packet_id, ids[i]);
      end
      step();
      vectors++;
      if (mem_mode !== 3'b000 || mem_packet_id !== 4'h0) begin
        miscompares++; $display("FAIL fire_end[%0d] got mode=%b id=%h exp 000/0", i, mem_mode, mem_packet_id);
      end
`ifdef TCAM_SCHED_FIRE_CNT_EN
      vectors++;
      if (fire_cnt !== 16'(i + 1)) begin miscompares++; $display("FAIL fire_cnt[%0d] got %0d exp %0d", i, fire_cnt, i + 1); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reserved();
    test_arbitration();
    test_reset_mid_read();
    test_reinit();
    test_fire();
    test_reinit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
